// File: rtl/timer_event_ack_if.sv
// Handshake bundle between the sticky overflow flag, the acknowledge logic and the host.
// The slave modport is the acknowledge block; master is the flag/host side driving it.
interface timer_event_ack_if #(
  parameter int CNT_W = 8
);
  logic             iTimerOverflow;
  logic             iComparisonTrue;
  logic             iAck;
  logic             oIrq;
  logic             oClearFlag;
  logic [CNT_W-1:0] oEventCount;
  logic [CNT_W-1:0] oOverrunCount;
  logic             oTimeout;

  modport master (
    output iTimerOverflow, iComparisonTrue, iAck,
    input  oIrq, oClearFlag, oEventCount, oOverrunCount, oTimeout
  );

  modport slave (
    input  iTimerOverflow, iComparisonTrue, iAck,
    output oIrq, oClearFlag, oEventCount, oOverrunCount, oTimeout
  );
endinterface

// File: rtl/timer_event_ack.sv
// Services the sticky timer-overflow flag: raises an IRQ, waits for an acknowledge or
// timeout, pulses the flag clear, and keeps event/overrun statistics.
module timer_event_ack #(
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TO_W           = 16
) (
  input  logic              iClk,
  input  logic              iReset,
  timer_event_ack_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLEAR   = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  localparam bit               TO_EN       = (TIMEOUT_CYCLES != 0);
  localparam int               TO_LAST_INT = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TO_LAST_INT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_t           state_r;
  logic [TO_W-1:0]  toCount_r;
  logic             irq_r;
  logic             clearFlag_r;
  logic [CNT_W-1:0] eventCount_r;
  logic [CNT_W-1:0] overrunCount_r;
  logic             timeout_r;
  logic             overrunHit_s;
  logic             toExpired_s;

  // A hit while an event is still outstanding cannot be represented by the flag, so count it
  assign overrunHit_s = bus.iComparisonTrue &&
                        ((state_r == PENDING) || (state_r == CLEAR)) &&
                        (overrunCount_r != CNT_MAX);
  assign toExpired_s  = TO_EN && (toCount_r == TO_LAST);

  // Event FSM with registered IRQ/clear outputs and statistics
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_r        <= IDLE;
      toCount_r      <= '0;
      irq_r          <= 1'b0;
      clearFlag_r    <= 1'b0;
      eventCount_r   <= '0;
      overrunCount_r <= '0;
      timeout_r      <= 1'b0;
    end else begin
      if (overrunHit_s) begin
        overrunCount_r <= overrunCount_r + CNT_ONE;
      end else begin
        overrunCount_r <= overrunCount_r;
      end

      case (state_r)
        IDLE: begin
          toCount_r   <= '0;
          clearFlag_r <= 1'b0;
          if (bus.iTimerOverflow) begin
            state_r      <= PENDING;
            irq_r        <= 1'b1;
            eventCount_r <= eventCount_r + CNT_ONE;
          end else begin
            state_r <= IDLE;
            irq_r   <= 1'b0;
          end
        end

        PENDING: begin
          // Acknowledge takes priority over a timeout expiring in the same cycle
          if (bus.iAck) begin
            state_r     <= CLEAR;
            irq_r       <= 1'b0;
            clearFlag_r <= 1'b1;
          end else if (toExpired_s) begin
            state_r     <= CLEAR;
            irq_r       <= 1'b0;
            clearFlag_r <= 1'b1;
            timeout_r   <= 1'b1;
          end else begin
            state_r     <= PENDING;
            irq_r       <= 1'b1;
            clearFlag_r <= 1'b0;
            toCount_r   <= toCount_r + TO_W'(1);
          end
        end

        CLEAR: begin
          state_r     <= DRAIN;
          irq_r       <= 1'b0;
          clearFlag_r <= 1'b0;
        end

        // The flag block is settling; it is deliberately not sampled here
        DRAIN: begin
          state_r     <= IDLE;
          irq_r       <= 1'b0;
          clearFlag_r <= 1'b0;
        end

        default: begin
          state_r     <= IDLE;
          irq_r       <= 1'b0;
          clearFlag_r <= 1'b0;
          toCount_r   <= '0;
        end
      endcase
    end
  end

  assign bus.oIrq          = irq_r;
  assign bus.oClearFlag    = clearFlag_r;
  assign bus.oEventCount   = eventCount_r;
  assign bus.oOverrunCount = overrunCount_r;
  assign bus.oTimeout      = timeout_r;

endmodule

// File: tb/tb_timer_event_ack.sv
// Scoreboard bench for timer_event_ack: directed stimulus pushes expectations, a monitor
// pops them on each clear pulse or at scheduled cycles and compares.
module tb_timer_event_ack;

  localparam int CNT_W = 8;
  localparam int TOC   = 10;

  typedef struct {
    string      name;
    int         irqLen;
    logic [7:0] evt;
    logic [7:0] ovr;
    logic       to;
  } clrExp_t;

  typedef struct {
    string      name;
    int         cyc;
    logic       irq;
    logic       clr;
    logic [7:0] evt;
    logic [7:0] ovr;
    logic       to;
  } snap_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flag = 1'b0;
  int   cyc = 0;
  int   nCompared = 0;
  int   nMismatch = 0;
  int   irqRun = 0;
  logic prevClr = 1'b0;

  clrExp_t clrQ[$];
  snap_t   snapQ[$];
  clrExp_t ce;
  snap_t   se;

  timer_event_ack_if #(.CNT_W(CNT_W)) bus ();

  timer_event_ack #(
    .CNT_W(CNT_W),
    .TIMEOUT_CYCLES(TOC),
    .TO_W(16)
  ) dut (
    .iClk(clk),
    .iReset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sticky flag environment model: clear has priority over a simultaneous hit
  always @(posedge clk) begin
    if (bus.oClearFlag) flag <= 1'b0;
    else if (bus.iComparisonTrue) flag <= 1'b1;
  end
  assign bus.iTimerOverflow = flag;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pop a per-event expectation on every clear pulse, and scheduled snapshots
  always @(negedge clk) begin
    if (rst) begin
      irqRun = 0;
      prevClr = 1'b0;
    end else begin
      if (bus.oIrq) irqRun++;
      if (bus.oClearFlag) begin
        if (clrQ.size() == 0) begin
          chk("unexpected_clear", 32'd1, 32'd0);
        end else begin
          ce = clrQ.pop_front();
          chk({ce.name, "_irq_len"}, irqRun, ce.irqLen);
          chk({ce.name, "_evt"}, {24'd0, bus.oEventCount}, {24'd0, ce.evt});
          chk({ce.name, "_ovr"}, {24'd0, bus.oOverrunCount}, {24'd0, ce.ovr});
          chk({ce.name, "_timeout"}, {31'd0, bus.oTimeout}, {31'd0, ce.to});
          chk({ce.name, "_clr_width"}, {31'd0, prevClr}, 32'd0);
        end
        irqRun = 0;
      end
      prevClr = bus.oClearFlag;
    end
    while (snapQ.size() > 0 && snapQ[0].cyc <= cyc) begin
      se = snapQ.pop_front();
      chk({se.name, "_cyc"}, cyc, se.cyc);
      chk({se.name, "_irq"}, {31'd0, bus.oIrq}, {31'd0, se.irq});
      chk({se.name, "_clr"}, {31'd0, bus.oClearFlag}, {31'd0, se.clr});
      chk({se.name, "_evt"}, {24'd0, bus.oEventCount}, {24'd0, se.evt});
      chk({se.name, "_ovr"}, {24'd0, bus.oOverrunCount}, {24'd0, se.ovr});
      chk({se.name, "_timeout"}, {31'd0, bus.oTimeout}, {31'd0, se.to});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitFor(input string nm, input bit useClr);
    int n = 0;
    while (!(useClr ? bus.oClearFlag : bus.oIrq) && n < 40) begin
      tick(1);
      n++;
    end
    if (!(useClr ? bus.oClearFlag : bus.oIrq)) chk({nm, "_wait_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic pushClr(input string nm, input int len, input logic [7:0] evt,
                         input logic [7:0] ovr, input logic to);
    clrExp_t e;
    e.name = nm; e.irqLen = len; e.evt = evt; e.ovr = ovr; e.to = to;
    clrQ.push_back(e);
  endtask

  task automatic pushSnap(input string nm, input int at, input logic irq, input logic clr,
                          input logic [7:0] evt, input logic [7:0] ovr, input logic to);
    snap_t s;
    s.name = nm; s.cyc = at; s.irq = irq; s.clr = clr; s.evt = evt; s.ovr = ovr; s.to = to;
    snapQ.push_back(s);
  endtask

  task automatic pulseCmp();
    bus.iComparisonTrue = 1'b1;
    tick(1);
    bus.iComparisonTrue = 1'b0;
  endtask

  // One event serviced with iAck already high; returns in the DRAIN cycle
  task automatic serviceEvent(input string nm);
    pulseCmp();
    waitFor(nm, 1'b1);
    tick(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iComparisonTrue = 1'b0;
    bus.iAck = 1'b0;
    rst = 1'b1;
    tick(3);
    pushSnap("reset", cyc, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    tick(1);
    rst = 1'b0;
    tick(2);

    // Acknowledge three cycles into the IRQ
    pushClr("t1_event", 3, 8'd1, 8'd0, 1'b0);
    pulseCmp();
    waitFor("t1_irq", 1'b0);
    pushSnap("t1_irq_rise", cyc, 1'b1, 1'b0, 8'd1, 8'd0, 1'b0);
    tick(2);
    bus.iAck = 1'b1;
    pushSnap("t1_clear_pulse", cyc + 1, 1'b0, 1'b1, 8'd1, 8'd0, 1'b0);
    pushSnap("t1_clear_end", cyc + 2, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0);
    tick(1);
    bus.iAck = 1'b0;
    tick(4);

    // 256 back-to-back events, iAck held high: count wraps through 0xFF -> 0x00
    bus.iAck = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pushClr("t2_event", 1, 8'(i + 2), 8'd0, 1'b0);
      serviceEvent("t2_event");
    end
    bus.iAck = 1'b0;
    tick(3);
    pushSnap("t2_after_wrap", cyc, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0);
    tick(1);

    // No acknowledge: forced clear after TOC PENDING cycles
    pushClr("t3_timeout", TOC, 8'd2, 8'd0, 1'b1);
    pulseCmp();
    waitFor("t3_clr", 1'b1);
    pushSnap("t3_clear", cyc, 1'b0, 1'b1, 8'd2, 8'd0, 1'b1);
    tick(1);
    bus.iAck = 1'b1;
    pushClr("t3_sticky", 1, 8'd3, 8'd0, 1'b1);
    serviceEvent("t3_sticky");
    bus.iAck = 1'b0;
    tick(3);
    pushSnap("t3_still_set", cyc, 1'b0, 1'b0, 8'd3, 8'd0, 1'b1);
    rst = 1'b1;
    tick(1);
    pushSnap("t3_reset", cyc, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    rst = 1'b0;
    tick(2);

    // 30 events x 10 hits in PENDING/CLEAR: overrun saturates at 0xFF
    for (int i = 0; i < 30; i++) begin
      pushClr("t4_ovr", 9, 8'(i + 1), ((10 * i + 9) > 255) ? 8'hFF : 8'(10 * i + 9), 1'b0);
      pulseCmp();
      waitFor("t4_irq", 1'b0);
      bus.iComparisonTrue = 1'b1;
      tick(8);
      bus.iAck = 1'b1;
      tick(1);
      bus.iAck = 1'b0;
      tick(1);
      bus.iComparisonTrue = 1'b0;
    end
    tick(4);
    pushSnap("t4_saturated_noflag", cyc, 1'b0, 1'b0, 8'd30, 8'hFF, 1'b0);
    tick(1);

    // iAck in the very cycle the timeout would expire
    pushClr("t5_ack_vs_timeout", TOC, 8'd31, 8'hFF, 1'b0);
    pulseCmp();
    waitFor("t5_irq", 1'b0);
    tick(TOC - 1);
    bus.iAck = 1'b1;
    tick(1);
    pushSnap("t5_clear", cyc, 1'b0, 1'b1, 8'd31, 8'hFF, 1'b0);
    bus.iAck = 1'b0;
    tick(3);

    // Reset mid-PENDING with the flag left set: re-detected as a new event
    pulseCmp();
    waitFor("t5_irq2", 1'b0);
    pushSnap("t5_pending", cyc, 1'b1, 1'b0, 8'd32, 8'hFF, 1'b0);
    tick(2);
    rst = 1'b1;
    pushSnap("t5_in_reset", cyc + 1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    tick(2);
    rst = 1'b0;
    pushSnap("t5_redetect", cyc + 1, 1'b1, 1'b0, 8'd1, 8'd0, 1'b0);
    pushClr("t5_after_reset", 1, 8'd1, 8'd0, 1'b0);
    tick(1);
    bus.iAck = 1'b1;
    tick(1);
    bus.iAck = 1'b0;
    tick(5);

    chk("scoreboard_drained", clrQ.size() + snapQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/timer_event_ack.md
Name: timer_event_ack

Overview:
Consumer side of the sticky timer-overflow flag. Watches the flag, raises an interrupt request and waits for a software/host acknowledge. Then issues a one-cycle clear pulse back to the flag's reset input. Also keeps event and overrun statistics, and applies an acknowledge timeout so a flag cannot stay latched forever. Sits between the 8-bit counter/comparator path and the host/interrupt logic.

Parameters:
CNT_W, 8, width of oEventCount and oOverrunCount
TIMEOUT_CYCLES, 1000, PENDING cycles without iAck before forced clear; 0 disables the timeout
TO_W, 16, width of the internal timeout counter; must hold TIMEOUT_CYCLES

Ports:
iClk  in  1  system clock, rising edge
iReset  in  1  synchronous, active-high reset
iTimerOverflow  in  1  sticky overflow flag from the timer event block
iComparisonTrue  in  1  raw comparison-hit pulse, same source that sets the flag
iAck  in  1  acknowledge from host, level or pulse, sampled each cycle
oIrq  out  1  interrupt request, high while in PENDING
oClearFlag  out  1  one-cycle pulse; drives the flag block's reset/ack input
oEventCount  out  CNT_W  number of flag events serviced, wraps
oOverrunCount  out  CNT_W  comparison hits lost while an event was outstanding, saturates
oTimeout  out  1  sticky: an event was force-cleared by timeout

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is iClk and reset port is iReset.
- All outputs are registered or decoded only from the state register. No combinational path from input to output.
- Reset (wins over everything): state=IDLE, oIrq=0, oClearFlag=0, oEventCount=0, oOverrunCount=0, oTimeout=0, timeout counter=0.
- FSM states: IDLE, PENDING, CLEAR, DRAIN.
- IDLE:
  - iTimerOverflow=1 -> PENDING next cycle.
  - On that same edge, oEventCount += 1, modulo 2^CNT_W (0xFF -> 0x00).
  - Timeout counter is loaded with 0.
- PENDING:
  - oIrq=1.
  - iAck=1 -> CLEAR.
  - Otherwise the timeout counter increments. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1, set oTimeout=1 and go to CLEAR.
  - iAck and timeout in the same cycle: iAck wins and oTimeout is not set.
- CLEAR:
  - oClearFlag=1 for exactly this one cycle, oIrq=0.
  - Always -> DRAIN.
- DRAIN:
  - One cycle, flag settling. The flag block clears on the edge ending CLEAR, because its reset has priority over a simultaneous comparison hit.
  - Always -> IDLE. The flag is not evaluated in DRAIN.
- Latency:
  - Flag first seen high in cycle k gives oIrq=1 and the incremented oEventCount in cycle k+1.
  - iAck sampled in cycle m gives oClearFlag=1 in cycle m+1.
  - Flag low from cycle m+2. The earliest re-entry to PENDING is cycle m+4.
- Overrun counting:
  - iComparisonTrue=1 while state is PENDING or CLEAR -> oOverrunCount += 1.
  - Saturates at all-ones and never wraps.
  - A hit in DRAIN or IDLE is not an overrun; it sets the flag and is serviced normally.
- iAck is ignored in IDLE, CLEAR and DRAIN. Holding iAck high continuously gives exactly one PENDING cycle per event.
- oTimeout clears only on iReset.
- Reset during PENDING: oIrq drops the next cycle and counters go to 0. If the flag is still set after reset is released, the event is re-detected and counted (oEventCount=1).
- Flag already high when reset is released: the event is treated as new.

Test Plan:
- Reset, then set the flag and pulse iAck 3 cycles after oIrq rises -> oIrq high exactly 3 cycles, oClearFlag exactly 1 cycle (cycle after iAck), oEventCount=1, oTimeout=0.
- 256 back-to-back serviced events with iAck tied high -> oEventCount wraps 0xFF->0x00, oIrq high exactly 1 cycle per event, oOverrunCount=0.
- TIMEOUT_CYCLES=10, no iAck -> oIrq high 10 cycles, then oClearFlag pulse, oTimeout=1 and stays 1 through further events until iReset.
- 300 iComparisonTrue pulses while in PENDING -> oOverrunCount saturates at 0xFF. A comparison hit in the CLEAR cycle counts as an overrun and leaves no flag afterwards.
- iAck asserted in the same cycle the timeout expires -> normal clear, oTimeout stays 0. Then iReset asserted mid-PENDING with the flag held high -> oIrq=0 the cycle after reset, and after reset release oEventCount=1 and oIrq=1.
